// File: rtl/vr_arb_pkg.sv
// Shared definitions for valid/ready arbiters.
//   MAX_SRC     : largest supported number of senders
//   PTR_W       : width of a sender index at MAX_SRC
//   rr_pick_t   : result of a round-robin search (winner index + found flag)
//   arb_state_t : arbiter bookkeeping (rotating pointer and packet lock)
//   rr_pick()   : round-robin search, reusable by other arbiters
package vr_arb_pkg;

  localparam int MAX_SRC = 16;
  localparam int PTR_W   = $clog2(MAX_SRC);

  typedef struct packed {
    logic [PTR_W-1:0] idx;
    logic             found;
  } rr_pick_t;

  typedef struct packed {
    logic [PTR_W-1:0] rr_ptr;
    logic             lock_active;
    logic [PTR_W-1:0] lock_src;
  } arb_state_t;

  // Scan req starting at ptr and wrapping at num. The scan offset k is the
  // rotated position; adding ptr back (mod num) un-rotates it into a real
  // sender index. Only the first hit is kept, which is the priority encode.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [PTR_W-1:0]   ptr,
                                       input int                 num);
    rr_pick_t r;
    int       i;
    r = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      if (k < num) begin
        i = int'(ptr) + k;
        if (i >= num) i -= num;
        if (!r.found && req[i[PTR_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = i[PTR_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner selection.
//   req    : request vector, bit i = sender i
//   ptr    : sender with highest priority this cycle
//   winner : first requesting sender at or after ptr (wrapping)
//   found  : at least one request present
module rr_priority_pick
  import vr_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   winner,
  output logic               found
);

  rr_pick_t pick;

  always_comb begin
    pick   = rr_pick(MAX_SRC'(req), PTR_W'(ptr), NUM_SRC);
    winner = SRC_W'(pick.idx);
    found  = pick.found;
  end

endmodule

// File: rtl/valid_ready_rr_arbiter.sv
// N-to-1 round-robin arbiter with valid/ready on every port and a single
// registered output stage (1 beat/cycle). Each beat carries its sender index.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_data      : per-sender request and payload
//   in_ready              : per-sender grant, at most one bit high
//   out_valid/out_data    : registered beat toward the downstream stage
//   out_src               : sender that supplied the current beat
//   out_ready             : downstream ready
// Optional macro VR_ARB_PKT_LOCK_EN adds in_last/out_last; once a non-last
// beat is accepted the grant stays with that sender until its last beat.
module valid_ready_rr_arbiter
  import vr_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = 8,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        in_valid,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
`ifdef VR_ARB_PKT_LOCK_EN
  input  logic [NUM_SRC-1:0]        in_last,
  output logic                      out_last,
`endif
  output logic [NUM_SRC-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready
);

  arb_state_t         st;
  logic               load_en;
  logic [NUM_SRC-1:0] req;
  logic [SRC_W-1:0]   winner;
  logic               found;
  logic [DATA_W-1:0]  win_data;
  logic [PTR_W:0]     ptr_inc;
  logic [PTR_W-1:0]   next_ptr;

  // The output register may take a new beat when empty or draining this edge.
  assign load_en = !out_valid || out_ready;

  // While a packet is locked, only its owner is allowed to request. Without
  // the lock feature lock_active never leaves 0 and this is just in_valid.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = in_valid[i] && (!st.lock_active || PTR_W'(i) == st.lock_src);
    end
  end

  rr_priority_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req    (req),
    .ptr    (SRC_W'(st.rr_ptr)),
    .winner (winner),
    .found  (found)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready = '0;
    if (found && load_en && !reset) in_ready[winner] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == winner) win_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Pointer moves to the sender after the winner, wrapping at NUM_SRC.
  assign ptr_inc  = {1'b0, PTR_W'(winner)} + (PTR_W+1)'(1);
  assign next_ptr = (ptr_inc >= (PTR_W+1)'(NUM_SRC)) ? '0 : ptr_inc[PTR_W-1:0];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      st        <= '0;
`ifdef VR_ARB_PKT_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (load_en) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_src   <= winner;
        st.rr_ptr <= next_ptr;
`ifdef VR_ARB_PKT_LOCK_EN
        out_last       <= in_last[winner];
        st.lock_active <= !in_last[winner];
        st.lock_src    <= PTR_W'(winner);
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
